ram_bank_sched: RTL

RAM_BANK_SCHED -- requirements
Module: ram_bank_sched

---
 rtl/ram_bank_sched_if.sv | 98 +++++++++
 rtl/ram_bank_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ram_bank_sched_if.sv
// Signal bundle between the bank scheduler and its writers,
// the Round engine, the VGA reader and the four RAM banks.
interface ram_bank_sched_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 32
);

   logic                          mode_run;
   logic                          clear;
   logic                          evo_tick;
   logic                          round_done;
   logic                          round_start;

   logic [2:0]                    wr_req;
   logic [2:0]                    wr_gnt;
   logic [2:0]                    wr_we;
   logic [2:0][ADDR_W-1:0]        wr_addr;
   logic [2:0][DATA_W-1:0]        wr_data;

   logic [ADDR_W-1:0]             round_rd_addr;
   logic [ADDR_W-1:0]             round_wr_addr;
   logic [DATA_W-1:0]             round_wr_data;
   logic                          round_we;
   logic [DATA_W-1:0]             round_rd_data;

   logic [ADDR_W-1:0]             vga_addr;
   logic [DATA_W-1:0]             vga_data;
   logic                          vga_blank;

   logic [3:0][ADDR_W-1:0]        bank_addr;
   logic [3:0][DATA_W-1:0]        bank_wdata;
   logic [3:0]                    bank_we;
   logic [3:0]                    bank_re;
   logic [3:0][DATA_W-1:0]        bank_rdata;

   logic                          sel;
   logic [15:0]                   gen_cnt;
   logic                          tick_overrun;

   modport master (
      input  mode_run,
      input  clear,
      input  evo_tick,
      input  round_done,
      output round_start,
      input  wr_req,
      output wr_gnt,
      input  wr_we,
      input  wr_addr,
      input  wr_data,
      input  round_rd_addr,
      input  round_wr_addr,
      input  round_wr_data,
      input  round_we,
      output round_rd_data,
      input  vga_addr,
      output vga_data,
      output vga_blank,
      output bank_addr,
      output bank_wdata,
      output bank_we,
      output bank_re,
      input  bank_rdata,
      output sel,
      output gen_cnt,
      output tick_overrun
   );

   modport slave (
      output mode_run,
      output clear,
      output evo_tick,
      output round_done,
      input  round_start,
      output wr_req,
      input  wr_gnt,
      output wr_we,
      output wr_addr,
      output wr_data,
      output round_rd_addr,
      output round_wr_addr,
      output round_wr_data,
      output round_we,
      input  round_rd_data,
      output vga_addr,
      input  vga_data,
      input  vga_blank,
      input  bank_addr,
      input  bank_wdata,
      input  bank_we,
      input  bank_re,
      output bank_rdata,
      input  sel,
      input  gen_cnt,
      input  tick_overrun
   );

endinterface

// File: rtl/ram_bank_sched.sv
// Four-bank ping-pong scheduler: loads a pattern, then alternates
// source/destination bank pairs once per Round generation.
module ram_bank_sched #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   ram_bank_sched_if.master bus
);

   typedef enum logic [1:0] {
      S_LOAD,
      S_HOLD,
      S_EVOLVE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  wr_gnt_q, wr_gnt_d;
   logic        sel_q, sel_d;
   logic [15:0] gen_cnt_q, gen_cnt_d;
   logic        round_start_q, round_start_d;
   logic        tick_overrun_q, tick_overrun_d;

   logic [2:0]        req_pick;
   logic [1:0]        gidx;
   logic [1:0]        rd_bank;
   logic [1:0]        vga_bank;
   logic [1:0]        dst_lo;
   logic [1:0]        dst_hi;
   logic              load_wr;
   logic              wr_strobe;
   logic [ADDR_W-1:0] wr_addr_sel;
   logic [DATA_W-1:0] wr_data_sel;

   // Fixed priority: init > preset > manual.
   always_comb begin
      req_pick = 3'b000;
      if (bus.wr_req[0]) begin
         req_pick = 3'b001;
      end else if (bus.wr_req[1]) begin
         req_pick = 3'b010;
      end else if (bus.wr_req[2]) begin
         req_pick = 3'b100;
      end
   end

   always_comb begin
      state_d        = state_q;
      wr_gnt_d       = 3'b000;
      sel_d          = sel_q;
      gen_cnt_d      = gen_cnt_q;
      round_start_d  = 1'b0;
      tick_overrun_d = tick_overrun_q;

      unique case (state_q)
         S_LOAD: begin
            if (|(wr_gnt_q & bus.wr_req)) begin
               wr_gnt_d = wr_gnt_q;
            end else begin
               wr_gnt_d = req_pick;
            end
            if (bus.mode_run && wr_gnt_q == 3'b000
                && bus.wr_req == 3'b000) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!bus.mode_run) begin
               state_d = S_LOAD;
            end else if (bus.evo_tick) begin
               state_d       = S_EVOLVE;
               round_start_d = 1'b1;
            end
         end
         S_EVOLVE: begin
            // A tick here means the rate outran the Round engine.
            if (bus.evo_tick) begin
               tick_overrun_d = 1'b1;
            end
            if (bus.round_done) begin
               sel_d     = ~sel_q;
               gen_cnt_d = gen_cnt_q + 16'd1;
               state_d   = bus.mode_run ? S_HOLD : S_LOAD;
            end
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase

      if (bus.clear) begin
         state_d        = S_LOAD;
         wr_gnt_d       = 3'b000;
         sel_d          = 1'b0;
         gen_cnt_d      = 16'd0;
         round_start_d  = 1'b0;
         tick_overrun_d = tick_overrun_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_LOAD;
         wr_gnt_q       <= 3'b000;
         sel_q          <= 1'b0;
         gen_cnt_q      <= 16'd0;
         round_start_q  <= 1'b0;
         tick_overrun_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_gnt_q       <= wr_gnt_d;
         sel_q          <= sel_d;
         gen_cnt_q      <= gen_cnt_d;
         round_start_q  <= round_start_d;
         tick_overrun_q <= tick_overrun_d;
      end
   end

   always_comb begin
      gidx = 2'd0;
      unique case (1'b1)
         wr_gnt_q[2]: gidx = 2'd2;
         wr_gnt_q[1]: gidx = 2'd1;
         default:     gidx = 2'd0;
      endcase
   end

   assign rd_bank     = {sel_q, 1'b0};
   assign vga_bank    = {sel_q, 1'b1};
   assign dst_lo      = {~sel_q, 1'b0};
   assign dst_hi      = {~sel_q, 1'b1};
   assign load_wr     = (state_q == S_LOAD) && (|wr_gnt_q);
   assign wr_strobe   = |(wr_gnt_q & bus.wr_we);
   assign wr_addr_sel = bus.wr_addr[gidx];
   assign wr_data_sel = bus.wr_data[gidx];

   always_comb begin
      bus.bank_addr  = '0;
      bus.bank_wdata = '0;
      bus.bank_we    = '0;
      bus.bank_re    = '0;
      if (load_wr) begin
         // The granted writer fills all four banks at once.
         for (int k = 0; k < 4; k++) begin
            bus.bank_addr[k]  = wr_addr_sel;
            bus.bank_wdata[k] = wr_data_sel;
            bus.bank_we[k]    = wr_strobe;
            bus.bank_re[k]    = 1'b1;
         end
      end else begin
         bus.bank_addr[vga_bank] = bus.vga_addr;
         bus.bank_re[vga_bank]   = 1'b1;
         if (state_q == S_EVOLVE) begin
            bus.bank_addr[rd_bank]  = bus.round_rd_addr;
            bus.bank_re[rd_bank]    = 1'b1;
            bus.bank_addr[dst_lo]   = bus.round_wr_addr;
            bus.bank_wdata[dst_lo]  = bus.round_wr_data;
            bus.bank_we[dst_lo]     = bus.round_we;
            bus.bank_re[dst_lo]     = 1'b1;
            bus.bank_addr[dst_hi]   = bus.round_wr_addr;
            bus.bank_wdata[dst_hi]  = bus.round_wr_data;
            bus.bank_we[dst_hi]     = bus.round_we;
            bus.bank_re[dst_hi]     = 1'b1;
         end
      end
   end

   always_comb begin
      bus.vga_data = '0;
      if (!load_wr) begin
         bus.vga_data = bus.bank_rdata[vga_bank];
      end
   end

   assign bus.round_rd_data = bus.bank_rdata[rd_bank];
   assign bus.vga_blank     = load_wr;
   assign bus.wr_gnt        = wr_gnt_q;
   assign bus.round_start   = round_start_q;
   assign bus.sel           = sel_q;
   assign bus.gen_cnt       = gen_cnt_q;
   assign bus.tick_overrun  = tick_overrun_q;

endmodule
